// File: rtl/runway_lights.sv
// -----------------------------------------------------------------------------
// runway_lights
//
// Runway landing-light sequencer. A programmable prescaler divides the board
// clock into steps; on every step the light bar either advances the pattern
// of the currently displayed mode or, if the mode input has changed, switches
// to the new mode and loads its entry pattern. The mode input is only looked
// at on step boundaries, so short glitches on the switches between steps are
// never displayed.
//
// Parameters
//   N_LIGHTS     number of lights in the bar (3..32)
//   DIV_W        width of step_div and of the prescaler counter
//
// Ports
//   clk          system clock, all state on the rising edge
//   reset        asynchronous active-low reset (0 = reset asserted)
//   enable       1 = run; 0 = prescaler, pattern and mode frozen
//   mode         00 calm, 01 right-to-left, 10 left-to-right, 11 strobe
//   step_div     step period minus one, in clk cycles
//   lights       light bar, bit 0 = rightmost light
//   tick         one-cycle pulse in the cycle the pattern updates
//   active_mode  mode currently being displayed
// -----------------------------------------------------------------------------
module runway_lights #(
    parameter int N_LIGHTS = 8,
    parameter int DIV_W    = 26
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [1:0]          mode,
    input  logic [DIV_W-1:0]    step_div,
    output logic [N_LIGHTS-1:0] lights,
    output logic                tick,
    output logic [1:0]          active_mode
);

    localparam logic [1:0] MODE_CALM = 2'b00;
    localparam logic [1:0] MODE_RTL  = 2'b01;
    localparam logic [1:0] MODE_LTR  = 2'b10;
    localparam logic [1:0] MODE_STRB = 2'b11;

    localparam logic [N_LIGHTS-1:0] ALL_ZERO = {N_LIGHTS{1'b0}};
    localparam logic [N_LIGHTS-1:0] ALL_ONE  = {N_LIGHTS{1'b1}};
    localparam logic [N_LIGHTS-1:0] LSB_ONE  = {{(N_LIGHTS-1){1'b0}}, 1'b1};
    localparam logic [N_LIGHTS-1:0] MSB_ONE  = {1'b1, {(N_LIGHTS-1){1'b0}}};

    localparam logic [DIV_W-1:0] CNT_ZERO = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] CNT_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

    // Calm pattern A: every even-index light on.
    function automatic logic [N_LIGHTS-1:0] calm_pattern();
        logic [N_LIGHTS-1:0] p;
        p = ALL_ZERO;
        for (int i = 0; i < N_LIGHTS; i += 2) begin
            p[i] = 1'b1;
        end
        return p;
    endfunction

    localparam logic [N_LIGHTS-1:0] CALM_A = calm_pattern();
    localparam logic [N_LIGHTS-1:0] CALM_B = ~CALM_A;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    function automatic logic is_onehot(input logic [N_LIGHTS-1:0] p);
        logic [N_LIGHTS-1:0] m;
        m = p - LSB_ONE;
        return (p != ALL_ZERO) && ((p & m) == ALL_ZERO);
    endfunction

    // Pattern shown on the first step after entering a mode.
    function automatic logic [N_LIGHTS-1:0] entry_pattern(input logic [1:0] m);
        logic [N_LIGHTS-1:0] p;
        case (m)
            MODE_CALM: p = CALM_A;
            MODE_RTL:  p = LSB_ONE;
            MODE_LTR:  p = MSB_ONE;
            MODE_STRB: p = ALL_ONE;
            default:   p = CALM_A;
        endcase
        return p;
    endfunction

    // True when p is one of the patterns the given mode can display.
    function automatic logic is_legal(input logic [1:0] m, input logic [N_LIGHTS-1:0] p);
        logic ok;
        case (m)
            MODE_CALM: ok = (p == CALM_A) || (p == CALM_B);
            MODE_RTL:  ok = is_onehot(p);
            MODE_LTR:  ok = is_onehot(p);
            MODE_STRB: ok = (p == ALL_ONE) || (p == ALL_ZERO);
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

    // One step of the mode's animation, assuming p is already legal.
    function automatic logic [N_LIGHTS-1:0] advance(input logic [1:0] m, input logic [N_LIGHTS-1:0] p);
        logic [N_LIGHTS-1:0] n;
        case (m)
            MODE_CALM: n = (p == CALM_A) ? CALM_B : CALM_A;
            MODE_RTL:  n = {p[N_LIGHTS-2:0], p[N_LIGHTS-1]};
            MODE_LTR:  n = {p[0], p[N_LIGHTS-1:1]};
            MODE_STRB: n = (p == ALL_ONE) ? ALL_ZERO : ALL_ONE;
            default:   n = CALM_A;
        endcase
        return n;
    endfunction

    logic [DIV_W-1:0]    cnt_q,    cnt_d;
    logic                tick_q,   tick_d;
    logic [N_LIGHTS-1:0] lights_q, lights_d;
    logic [1:0]          mode_q,   mode_d;
    logic                step_s;

    // State register: prescaler, tick pulse, displayed pattern and mode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= CNT_ZERO;
            tick_q   <= 1'b0;
            lights_q <= CALM_A;
            mode_q   <= MODE_CALM;
        end else begin
            cnt_q    <= cnt_d;
            tick_q   <= tick_d;
            lights_q <= lights_d;
            mode_q   <= mode_d;
        end
    end

    // Prescaler: the >= compare lets a lowered step_div fire at once instead
    // of waiting for the counter to wrap.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        step_s = 1'b0;
        if (enable) begin
            if (cnt_q >= step_div) begin
                cnt_d  = CNT_ZERO;
                tick_d = 1'b1;
                step_s = 1'b1;
            end else begin
                cnt_d  = cnt_q + CNT_ONE;
            end
        end else begin
            cnt_d  = cnt_q;
        end
    end

    // Next pattern: mode is sampled only on a step; a changed mode (including
    // a direct reversal) restarts at its entry pattern, and an illegal pattern
    // is repaired by reloading the entry pattern.
    always_comb begin
        lights_d = lights_q;
        mode_d   = mode_q;
        if (step_s) begin
            if (mode != mode_q) begin
                mode_d   = mode;
                lights_d = entry_pattern(mode);
            end else if (!is_legal(mode_q, lights_q)) begin
                lights_d = entry_pattern(mode_q);
            end else begin
                lights_d = advance(mode_q, lights_q);
            end
        end else begin
            lights_d = lights_q;
            mode_d   = mode_q;
        end
    end

    // Outputs come straight from flops.
    assign lights      = lights_q;
    assign tick        = tick_q;
    assign active_mode = mode_q;

endmodule

// File: tb/tb_runway_lights.sv
// -----------------------------------------------------------------------------
// tb_runway_lights
//
// Directed bench for runway_lights. An 8-light and a 3-light instance share
// all inputs, so their prescalers run in lockstep and both light bars can be
// checked on every step. Each table row gives the inputs for one step, the
// number of cycles until the tick is expected, and the resulting patterns.
// -----------------------------------------------------------------------------
module tb_runway_lights;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [1:0]  mode;
    logic [25:0] step_div;
    logic [7:0]  lights8;
    logic        tick8;
    logic [1:0]  amode8;
    logic [2:0]  lights3;
    logic        tick3;
    logic [1:0]  amode3;

    int errors = 0;
    int checks = 0;

    runway_lights #(.N_LIGHTS(8), .DIV_W(26)) dut8 (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode),
        .step_div(step_div), .lights(lights8), .tick(tick8), .active_mode(amode8)
    );

    runway_lights #(.N_LIGHTS(3), .DIV_W(26)) dut3 (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode),
        .step_div(step_div), .lights(lights3), .tick(tick3), .active_mode(amode3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic [25:0] div;
        int          cycles;
        logic [7:0]  exp8;
        logic [1:0]  exp_mode;
        logic [2:0]  exp3;
    } step_t;

    step_t tbl1[$];
    step_t tbl2[$];

    function automatic step_t mk(input logic [1:0] m, input logic [25:0] d, input int c,
                                 input logic [7:0] e8, input logic [1:0] em, input logic [2:0] e3);
        step_t s;
        s.mode = m; s.div = d; s.cycles = c; s.exp8 = e8; s.exp_mode = em; s.exp3 = e3;
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Apply one row, wait (bounded) for the tick, then compare both bars.
    task automatic run_step(input step_t s, input string name);
        int k;
        logic got;
        mode = s.mode; step_div = s.div; enable = 1'b1;
        k = 0; got = 1'b0;
        while (!got && k < 2000) begin
            @(posedge clk); #1;
            k++;
            if (tick8) got = 1'b1;
        end
        chk({name, ".cycles"}, k, s.cycles);
        chk({name, ".lights8"}, {24'd0, lights8}, {24'd0, s.exp8});
        chk({name, ".mode8"}, {30'd0, amode8}, {30'd0, s.exp_mode});
        chk({name, ".lights3"}, {29'd0, lights3}, {29'd0, s.exp3});
        chk({name, ".tick3"}, {31'd0, tick3}, 32'd1);
    endtask

    initial begin
        int tick_seen;

        // Calm, right-to-left with wrap, reversal, left-to-right with wrap, strobe.
        tbl1.push_back(mk(2'b00, 26'd2, 3, 8'hAA, 2'b00, 3'b010));
        tbl1.push_back(mk(2'b00, 26'd2, 3, 8'h55, 2'b00, 3'b101));
        tbl1.push_back(mk(2'b01, 26'd2, 3, 8'h01, 2'b01, 3'b001));
        tbl1.push_back(mk(2'b01, 26'd2, 3, 8'h02, 2'b01, 3'b010));
        tbl1.push_back(mk(2'b01, 26'd2, 3, 8'h04, 2'b01, 3'b100));
        tbl1.push_back(mk(2'b01, 26'd2, 3, 8'h08, 2'b01, 3'b001));
        tbl1.push_back(mk(2'b01, 26'd2, 3, 8'h10, 2'b01, 3'b010));
        tbl1.push_back(mk(2'b01, 26'd2, 3, 8'h20, 2'b01, 3'b100));
        tbl1.push_back(mk(2'b01, 26'd2, 3, 8'h40, 2'b01, 3'b001));
        tbl1.push_back(mk(2'b01, 26'd2, 3, 8'h80, 2'b01, 3'b010));
        tbl1.push_back(mk(2'b01, 26'd2, 3, 8'h01, 2'b01, 3'b100));
        tbl1.push_back(mk(2'b01, 26'd2, 3, 8'h02, 2'b01, 3'b001));
        tbl1.push_back(mk(2'b01, 26'd2, 3, 8'h04, 2'b01, 3'b010));
        tbl1.push_back(mk(2'b10, 26'd2, 3, 8'h80, 2'b10, 3'b100));
        tbl1.push_back(mk(2'b10, 26'd2, 3, 8'h40, 2'b10, 3'b010));
        tbl1.push_back(mk(2'b10, 26'd2, 3, 8'h20, 2'b10, 3'b001));
        tbl1.push_back(mk(2'b10, 26'd2, 3, 8'h10, 2'b10, 3'b100));
        tbl1.push_back(mk(2'b10, 26'd2, 3, 8'h08, 2'b10, 3'b010));
        tbl1.push_back(mk(2'b10, 26'd2, 3, 8'h04, 2'b10, 3'b001));
        tbl1.push_back(mk(2'b10, 26'd2, 3, 8'h02, 2'b10, 3'b100));
        tbl1.push_back(mk(2'b10, 26'd2, 3, 8'h01, 2'b10, 3'b010));
        tbl1.push_back(mk(2'b10, 26'd2, 3, 8'h80, 2'b10, 3'b001));
        tbl1.push_back(mk(2'b11, 26'd0, 1, 8'hFF, 2'b11, 3'b111));
        tbl1.push_back(mk(2'b11, 26'd0, 1, 8'h00, 2'b11, 3'b000));
        tbl1.push_back(mk(2'b11, 26'd0, 1, 8'hFF, 2'b11, 3'b111));

        // After the mid-sequence reset: calm then right-to-left on both widths.
        tbl2.push_back(mk(2'b00, 26'd2, 3, 8'hAA, 2'b00, 3'b010));
        tbl2.push_back(mk(2'b00, 26'd2, 3, 8'h55, 2'b00, 3'b101));
        tbl2.push_back(mk(2'b01, 26'd2, 3, 8'h01, 2'b01, 3'b001));
        tbl2.push_back(mk(2'b01, 26'd2, 3, 8'h02, 2'b01, 3'b010));
        tbl2.push_back(mk(2'b01, 26'd2, 3, 8'h04, 2'b01, 3'b100));
        tbl2.push_back(mk(2'b01, 26'd2, 3, 8'h08, 2'b01, 3'b001));

        // Power-on reset for 3 cycles.
        reset = 1'b0; enable = 1'b1; mode = 2'b00; step_div = 26'd2;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.lights8", {24'd0, lights8}, 32'h55);
        chk("rst.tick", {31'd0, tick8}, 32'd0);
        chk("rst.mode", {30'd0, amode8}, 32'd0);
        chk("rst.lights3", {29'd0, lights3}, 32'h5);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < tbl1.size(); i++) begin
            run_step(tbl1[i], $sformatf("t1[%0d]", i));
        end

        // Freeze: counter at 2 of a 5-cycle step, disable for 5 cycles.
        step_div = 26'd4;
        repeat (2) begin
            @(posedge clk); #1;
            chk("pre_freeze.tick", {31'd0, tick8}, 32'd0);
        end
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk($sformatf("freeze[%0d].tick", i), {31'd0, tick8}, 32'd0);
            chk($sformatf("freeze[%0d].lights", i), {24'd0, lights8}, 32'hFF);
        end
        // Held counter 2 needs 3 more cycles to reach 4 and fire.
        run_step(mk(2'b11, 26'd4, 3, 8'h00, 2'b11, 3'b000), "unfreeze");

        // Long step, mode glitch between ticks, then lower step_div below cnt.
        step_div = 26'd1000;
        tick_seen = 0;
        for (int i = 0; i < 500; i++) begin
            if (i == 100) mode = 2'b10;
            if (i == 103) mode = 2'b11;
            @(posedge clk); #1;
            if (tick8) tick_seen++;
        end
        chk("long.no_tick", tick_seen, 0);
        chk("long.lights", {24'd0, lights8}, 32'h00);
        chk("long.mode", {30'd0, amode8}, 32'd3);
        run_step(mk(2'b11, 26'd10, 1, 8'hFF, 2'b11, 3'b111), "lower_div");
        run_step(mk(2'b11, 26'd10, 11, 8'h00, 2'b11, 3'b000), "div10");

        // Walk to 00010000 in left-to-right, then reset off the clock edge.
        run_step(mk(2'b10, 26'd2, 3, 8'h80, 2'b10, 3'b100), "ltr_a");
        run_step(mk(2'b10, 26'd2, 3, 8'h40, 2'b10, 3'b010), "ltr_b");
        run_step(mk(2'b10, 26'd2, 3, 8'h20, 2'b10, 3'b001), "ltr_c");
        run_step(mk(2'b10, 26'd2, 3, 8'h10, 2'b10, 3'b100), "ltr_d");
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("async_rst.lights8", {24'd0, lights8}, 32'h55);
        chk("async_rst.mode8", {30'd0, amode8}, 32'd0);
        chk("async_rst.tick", {31'd0, tick8}, 32'd0);
        chk("async_rst.lights3", {29'd0, lights3}, 32'h5);
        chk("async_rst.mode3", {30'd0, amode3}, 32'd0);
        mode = 2'b00; step_div = 26'd2;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < tbl2.size(); i++) begin
            run_step(tbl2[i], $sformatf("t2[%0d]", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
